// File: rtl/tcp_encode.sv
// tcp_encode: serialises a 20-byte option-free TCP header onto a valid/ready byte stream.
// Define TCP_ENCODE_CHECKSUM_EN to compute the header + pseudo-header checksum before sending.
module tcp_encode #(
   parameter logic [15:0] URG_PTR = 16'h0000,
   parameter logic [7:0]  PROTO   = 8'd6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] source_port,
   input  logic [15:0] dest_port,
   input  logic [31:0] sequence_num,
   input  logic [31:0] ack_num,
   input  logic [7:0]  flags,
   input  logic [15:0] window,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   input  logic [15:0] tcp_length,
   output logic [7:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_last,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_CSUM, S_SEND} state_t;

   state_t        state_q;
   logic [4:0]    idx_q;
   logic [15:0]   sport_q, dport_q, window_q;
   logic [31:0]   seq_q, ack_q;
   logic [7:0]    flags_q;
   logic          dout_valid_q, dout_last_q, busy_q, done_q;
   logic [15:0]   csum_field;
   logic [159:0]  hdr_d;
   logic [4:0]    ridx_d;
   logic [7:0]    byte_d;

`ifdef TCP_ENCODE_CHECKSUM_EN
   logic [31:0]   src_ip_q, dst_ip_q, acc_q, sum_d;
   logic [15:0]   tcp_len_q, csum_q, word_d, fold2_d;
   logic [16:0]   fold1_d;
   logic [3:0]    cnt_q;

   // One 16-bit word per CSUM cycle; the checksum field itself counts as zero.
   always_comb begin
      word_d = '0;
      case (cnt_q)
         4'd0:    word_d = src_ip_q[31:16];
         4'd1:    word_d = src_ip_q[15:0];
         4'd2:    word_d = dst_ip_q[31:16];
         4'd3:    word_d = dst_ip_q[15:0];
         4'd4:    word_d = {8'h00, PROTO};
         4'd5:    word_d = tcp_len_q;
         4'd6:    word_d = sport_q;
         4'd7:    word_d = dport_q;
         4'd8:    word_d = seq_q[31:16];
         4'd9:    word_d = seq_q[15:0];
         4'd10:   word_d = ack_q[31:16];
         4'd11:   word_d = ack_q[15:0];
         4'd12:   word_d = {8'h50, flags_q};
         4'd13:   word_d = window_q;
         4'd14:   word_d = URG_PTR;
         default: word_d = '0;
      endcase
   end

   assign sum_d      = acc_q + {16'h0000, word_d};
   assign fold1_d    = {1'b0, sum_d[31:16]} + {1'b0, sum_d[15:0]};
   assign fold2_d    = fold1_d[15:0] + {15'd0, fold1_d[16]};
   assign csum_field = csum_q;
`else
   logic unused_pseudo;
   assign unused_pseudo = ^{src_ip, dst_ip, tcp_length, PROTO};
   assign csum_field    = 16'h0000;
`endif

   assign hdr_d  = {sport_q, dport_q, seq_q, ack_q, 8'h50, flags_q, window_q, csum_field, URG_PTR};
   assign ridx_d = 5'd19 - idx_q;
   assign byte_d = hdr_d[{ridx_d, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         sport_q      <= '0;
         dport_q      <= '0;
         seq_q        <= '0;
         ack_q        <= '0;
         flags_q      <= '0;
         window_q     <= '0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef TCP_ENCODE_CHECKSUM_EN
         src_ip_q     <= '0;
         dst_ip_q     <= '0;
         tcp_len_q    <= '0;
         csum_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sport_q  <= source_port;
                  dport_q  <= dest_port;
                  seq_q    <= sequence_num;
                  ack_q    <= ack_num;
                  flags_q  <= flags;
                  window_q <= window;
                  busy_q   <= 1'b1;
                  idx_q    <= '0;
`ifdef TCP_ENCODE_CHECKSUM_EN
                  src_ip_q  <= src_ip;
                  dst_ip_q  <= dst_ip;
                  tcp_len_q <= tcp_length;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  state_q   <= S_CSUM;
`else
                  dout_valid_q <= 1'b1;
                  state_q      <= S_SEND;
`endif
               end
            end
            S_CSUM: begin
`ifdef TCP_ENCODE_CHECKSUM_EN
               acc_q <= sum_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd14) begin
                  csum_q       <= ~fold2_d;
                  dout_valid_q <= 1'b1;
                  state_q      <= S_SEND;
               end
`else
               state_q <= S_IDLE;
`endif
            end
            S_SEND: begin
               if (dout_ready) begin
                  if (idx_q == 5'd19) begin
                     dout_valid_q <= 1'b0;
                     dout_last_q  <= 1'b0;
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                     idx_q        <= '0;
                     state_q      <= S_IDLE;
                  end else begin
                     idx_q       <= idx_q + 5'd1;
                     dout_last_q <= (idx_q == 5'd18);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dout       = dout_valid_q ? byte_d : 8'h00;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_tcp_encode.sv
// Directed bench for tcp_encode; follows TCP_ENCODE_CHECKSUM_EN for latency and checksum bytes.
`timescale 1ns/1ps
module tb_tcp_encode;

`ifdef TCP_ENCODE_CHECKSUM_EN
   localparam int          LAT      = 16;
   localparam logic [15:0] EXP_CSUM = 16'h1A0A;
`else
   localparam int          LAT      = 1;
   localparam logic [15:0] EXP_CSUM = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] source_port = '0, dest_port = '0, window = '0, tcp_length = '0;
   logic [31:0] sequence_num = '0, ack_num = '0, src_ip = '0, dst_ip = '0;
   logic [7:0]  flags = '0;
   logic        dout_ready = 1'b0;
   logic [7:0]  dout;
   logic        dout_valid, dout_last, busy, done;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_bytes [20];

   always #5 clk = ~clk;

   tcp_encode dut (
      .clk(clk), .rst(rst), .start(start),
      .source_port(source_port), .dest_port(dest_port),
      .sequence_num(sequence_num), .ack_num(ack_num),
      .flags(flags), .window(window),
      .src_ip(src_ip), .dst_ip(dst_ip), .tcp_length(tcp_length),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .busy(busy), .done(done)
   );

   task automatic set_fields();
      source_port  = 16'h1234;
      dest_port    = 16'h0050;
      sequence_num = 32'h0000_0001;
      ack_num      = 32'h0000_0000;
      flags        = 8'h02;
      window       = 16'hFFFF;
      src_ip       = 32'hC0A8_0101;
      dst_ip       = 32'hC0A8_0102;
      tcp_length   = 16'h0014;
   endtask

   task automatic check_idle(input string tag);
      vectors++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dout_last !== 1'b0 || dout !== 8'h00) begin
         miscompares++;
         $display("FAIL %s idle: valid=%b busy=%b done=%b last=%b dout=%h, want 0/0/0/0/00",
                  tag, dout_valid, busy, done, dout_last, dout);
      end
   endtask

   // Pulses start at the current negedge and returns at the negedge where byte 0 must be valid.
   task automatic start_and_wait(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         vectors++;
         if (dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_valid cycle %0d: valid=%b, want 0", tag, k, dout_valid);
         end
         @(negedge clk);
      end
      vectors++;
      if (dout_valid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s first_valid: valid=%b busy=%b, want 1/1", tag, dout_valid, busy);
      end
   endtask

   // mode 0: ready high; 1: toggled ready + 5-cycle stall at idx 7;
   // mode 2: second start at idx 3; 3: reset at idx 10.
   task automatic drive_frame(input string tag, input int mode);
      int idx = 0;
      int cyc = 0;
      int stall = 0;
      bit injected = 1'b0;
      bit rdy;
      while (idx < 20 && cyc < 300) begin
         rdy = 1'b1;
         if (mode == 1) begin
            if (idx == 7 && stall < 5) begin
               rdy = 1'b0;
               stall++;
            end else begin
               rdy = (cyc % 2 == 0);
            end
         end
         if (mode == 2) begin
            start = 1'b0;
            if (idx == 3 && !injected) begin
               start       = 1'b1;
               source_port = 16'hAAAA;
               dest_port   = 16'hBBBB;
               flags       = 8'h11;
               injected    = 1'b1;
            end
         end
         if (mode == 3 && idx == 10) begin
            rst = 1'b1;
            #1;
            vectors++;
            if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dout_last !== 1'b0) begin
               miscompares++;
               $display("FAIL %s abort: valid=%b busy=%b done=%b last=%b, want 0/0/0/0",
                        tag, dout_valid, busy, done, dout_last);
            end
            return;
         end
         dout_ready = rdy;
         vectors++;
         if (dout_valid !== 1'b1 || dout !== exp_bytes[idx] || busy !== 1'b1 || done !== 1'b0 ||
             dout_last !== ((idx == 19) ? 1'b1 : 1'b0)) begin
            miscompares++;
            $display("FAIL %s byte%0d: dout=%h valid=%b last=%b busy=%b done=%b, want %h/1/%b/1/0",
                     tag, idx, dout, dout_valid, dout_last, busy, done, exp_bytes[idx], (idx == 19));
         end
         if (rdy) idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      vectors++;
      if (idx < 20) begin
         miscompares++;
         $display("FAIL %s timeout: transferred %0d bytes, want 20", tag, idx);
      end
      vectors++;
      if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done_cycle: done=%b valid=%b busy=%b last=%b, want 1/0/0/0",
                  tag, done, dout_valid, busy, dout_last);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset");
   endtask

   task automatic test_basic();
      set_fields();
      dout_ready = 1'b1;
      start_and_wait("basic");
      drive_frame("basic", 0);
      @(negedge clk);
      check_idle("basic_after_done");
   endtask

   task automatic test_backpressure();
      set_fields();
      start_and_wait("bp");
      drive_frame("bp", 1);
      @(negedge clk);
      check_idle("bp_after_done");
   endtask

   task automatic test_ignored_start();
      set_fields();
      dout_ready = 1'b1;
      start_and_wait("ign");
      drive_frame("ign", 2);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check_idle("ign_no_second");
      end
   endtask

   task automatic test_reset_abort();
      set_fields();
      dout_ready = 1'b1;
      start_and_wait("abort");
      drive_frame("abort", 3);
      @(negedge clk);
      check_idle("abort_in_reset");
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_idle("abort_released");
      end
      start_and_wait("abort_restart");
      drive_frame("abort_restart", 0);
      @(negedge clk);
      check_idle("abort_restart_after");
   endtask

   task automatic test_back_to_back();
      set_fields();
      dout_ready = 1'b1;
      start_and_wait("b2b_first");
      drive_frame("b2b_first", 0);
      start_and_wait("b2b_second");
      drive_frame("b2b_second", 0);
      @(negedge clk);
      check_idle("b2b_after");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      exp_bytes[0]  = 8'h12; exp_bytes[1]  = 8'h34; exp_bytes[2]  = 8'h00; exp_bytes[3]  = 8'h50;
      exp_bytes[4]  = 8'h00; exp_bytes[5]  = 8'h00; exp_bytes[6]  = 8'h00; exp_bytes[7]  = 8'h01;
      exp_bytes[8]  = 8'h00; exp_bytes[9]  = 8'h00; exp_bytes[10] = 8'h00; exp_bytes[11] = 8'h00;
      exp_bytes[12] = 8'h50; exp_bytes[13] = 8'h02; exp_bytes[14] = 8'hFF; exp_bytes[15] = 8'hFF;
      exp_bytes[16] = EXP_CSUM[15:8]; exp_bytes[17] = EXP_CSUM[7:0];
      exp_bytes[18] = 8'h00; exp_bytes[19] = 8'h00;

      test_reset();
      test_basic();
      test_backpressure();
      test_ignored_start();
      test_reset_abort();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
